// File: rtl/cpu_mem_pkg.sv
// Shared constants for the CPU memory-port arbiter: owner encoding, halt opcode, bus width defaults.
package cpu_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;

  // Return-path owner of the access issued in the previous cycle
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_DM   = 2'd2;

  localparam logic [15:0] HALT_OPCODE = 16'hF000;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive denied fetch cycles; wait_max flags that fetch must win next.
module mem_arb_starve_ctr #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic fetch_ok,
  input  logic fetch_gnt,
  output logic wait_max
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!fetch_ok || fetch_gnt) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign wait_max = (cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data load/store.
// Data has priority with a starvation guard for fetch; fetching the halt opcode stops further fetches.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = cpu_mem_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W   = cpu_mem_pkg::DATA_W_DEF,
  parameter int unsigned MAX_WAIT = 4,
  parameter logic [DATA_W-1:0] HALT_OPCODE = DATA_W'(cpu_mem_pkg::HALT_OPCODE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              halted
);

  import cpu_mem_pkg::*;

  logic       fetch_ok;
  logic       wait_max;
  logic [1:0] owner;
  logic [1:0] owner_d;

  assign fetch_ok = if_req & ~halted;

  mem_arb_starve_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .fetch_ok (fetch_ok),
    .fetch_gnt(if_gnt),
    .wait_max (wait_max)
  );

  // Single-winner arbitration; grants held low while reset is asserted
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (rst) begin
      if (wait_max && fetch_ok) begin
        if_gnt = 1'b1;
      end else if (dm_req) begin
        dm_gnt = 1'b1;
      end else if (fetch_ok) begin
        if_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = if_gnt | dm_gnt;
    mem_we    = dm_gnt & dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dm_gnt) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  // Owner of next cycle's read data; writes return nothing
  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (dm_gnt && !dm_we) begin
      owner_d = OWN_DM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner <= OWN_NONE;
    end else begin
      owner <= owner_d;
    end
  end

  assign if_rvalid = (owner == OWN_IF);
  assign dm_rvalid = (owner == OWN_DM);
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

  // Sticky halt; a fetch granted while the halt word returns still completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted <= 1'b0;
    end else if (if_rvalid && (if_rdata == HALT_OPCODE)) begin
      halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level model checked every cycle.
module tb_mem_port_arbiter;
  import cpu_mem_pkg::*;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [15:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [15:0] dm_addr = '0;
  logic [15:0] dm_wdata = '0;
  logic        dm_gnt, dm_rvalid;
  logic [15:0] dm_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        halted;

  mem_port_arbiter #(
    .ADDR_W(16), .DATA_W(16), .MAX_WAIT(MW), .HALT_OPCODE(16'hF000)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bench-side memory: unwritten words read as address ^ A5A5
  logic [15:0] mem [logic [15:0]];

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 16'hA5A5;
  endfunction

  always @(posedge clk) begin
    if (rst && mem_en) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      else        mem_rdata <= mem_rd(mem_addr);
    end
  end

  // Model state: denied-fetch streak, halt flag and the one outstanding response
  int          m_denied = 0;
  bit          m_halted = 1'b0;
  bit          m_ifv = 1'b0;
  bit          m_dmv = 1'b0;
  logic [15:0] m_rdata = '0;

  always @(negedge rst) begin
    m_denied = 0;
    m_halted = 1'b0;
    m_ifv    = 1'b0;
    m_dmv    = 1'b0;
  end

  always @(negedge clk) begin
    bit          fok, e_if, e_dm;
    logic [15:0] e_addr, e_wd;
    if (!rst) begin
      chk("rst_if_gnt", 32'(if_gnt), 0);
      chk("rst_dm_gnt", 32'(dm_gnt), 0);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_if_rvalid", 32'(if_rvalid), 0);
      chk("rst_dm_rvalid", 32'(dm_rvalid), 0);
      chk("rst_halted", 32'(halted), 0);
    end else begin
      fok    = if_req && !m_halted;
      e_if   = fok && (m_denied == MW || !dm_req);
      e_dm   = dm_req && !e_if;
      e_addr = e_if ? if_addr : (e_dm ? dm_addr : 16'h0);
      e_wd   = e_dm ? dm_wdata : 16'h0;
      chk("if_gnt", 32'(if_gnt), 32'(e_if));
      chk("dm_gnt", 32'(dm_gnt), 32'(e_dm));
      chk("mem_en", 32'(mem_en), 32'(e_if | e_dm));
      chk("mem_we", 32'(mem_we), 32'(e_dm & dm_we));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
      chk("if_rvalid", 32'(if_rvalid), 32'(m_ifv));
      chk("dm_rvalid", 32'(dm_rvalid), 32'(m_dmv));
      chk("halted", 32'(halted), 32'(m_halted));
      if (m_ifv) chk("if_rdata", 32'(if_rdata), 32'(m_rdata));
      if (m_dmv) chk("dm_rdata", 32'(dm_rdata), 32'(m_rdata));
      if (m_ifv && m_rdata == 16'hF000) m_halted = 1'b1;
      m_denied = (fok && !e_if) ? ((m_denied < MW) ? m_denied + 1 : MW) : 0;
      m_ifv    = e_if;
      m_dmv    = e_dm && !dm_we;
      m_rdata  = mem_rd(e_addr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          gq[$];
  logic [15:0] bb_exp [3];

  initial begin
    mem[16'h0010] = 16'h1234;
    mem[16'h0030] = 16'hF000;
    mem[16'h0200] = 16'h5A5A;
    bb_exp[0] = 16'hA5A5;
    bb_exp[1] = 16'hA5A4;
    bb_exp[2] = 16'hA5A7;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    step();

    // Lone fetch
    if_req = 1'b1; if_addr = 16'h0010;
    @(negedge clk);
    chk("t1_if_gnt", 32'(if_gnt), 1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h0010);
    step(); if_req = 1'b0;
    @(negedge clk);
    chk("t1_if_rvalid", 32'(if_rvalid), 1);
    chk("t1_if_rdata", 32'(if_rdata), 32'h1234);
    step();

    // Write collides with fetch: data wins, no rvalid for the write
    if_req = 1'b1; if_addr = 16'h0020;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0100; dm_wdata = 16'hBEEF;
    @(negedge clk);
    chk("t2_dm_gnt", 32'(dm_gnt), 1);
    chk("t2_mem_we", 32'(mem_we), 1);
    chk("t2_mem_addr", 32'(mem_addr), 32'h0100);
    chk("t2_if_gnt", 32'(if_gnt), 0);
    step(); dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    chk("t2_dm_rvalid", 32'(dm_rvalid), 0);
    chk("t2_if_gnt_late", 32'(if_gnt), 1);
    step(); if_req = 1'b0;
    @(negedge clk);
    chk("t2_if_rdata", 32'(if_rdata), 32'hA585);
    step();

    // Starvation guard over 10 contended cycles
    if_req = 1'b1; if_addr = 16'h0040;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0300;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (if_gnt) gq.push_back(i);
      step();
    end
    if_req = 1'b0; dm_req = 1'b0;
    chk("t3_fetch_grant_count", 32'(gq.size()), 2);
    chk("t3_first_fetch_cycle", 32'((gq.size() > 0) ? gq[0] : -1), 5);
    chk("t3_second_fetch_cycle", 32'((gq.size() > 1) ? gq[1] : -1), 10);
    step();

    // Back-to-back fetches
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        if_req = 1'b1; if_addr = 16'(i);
      end else begin
        if_req = 1'b0;
      end
      @(negedge clk);
      if (i < 3) chk("t4_if_gnt", 32'(if_gnt), 1);
      if (i > 0) begin
        chk("t4_if_rvalid", 32'(if_rvalid), 1);
        chk("t4_if_rdata", 32'(if_rdata), 32'(bb_exp[i-1]));
      end
      step();
    end
    step();

    // Halt opcode fetch, with a fetch still issued while it returns
    if_req = 1'b1; if_addr = 16'h0030;
    @(negedge clk);
    chk("t5_if_gnt_halt_word", 32'(if_gnt), 1);
    step(); if_addr = 16'h0031;
    @(negedge clk);
    chk("t5_if_gnt_overlap", 32'(if_gnt), 1);
    chk("t5_if_rdata", 32'(if_rdata), 32'hF000);
    chk("t5_halted_pre", 32'(halted), 0);
    step(); if_addr = 16'h0032;
    @(negedge clk);
    chk("t5_halted", 32'(halted), 1);
    chk("t5_overlap_rvalid", 32'(if_rvalid), 1);
    chk("t5_if_gnt_blocked", 32'(if_gnt), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("t5_if_gnt_stays_blocked", 32'(if_gnt), 0);
    end
    step();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0200;
    @(negedge clk);
    chk("t5_dm_gnt", 32'(dm_gnt), 1);
    step(); dm_req = 1'b0;
    @(negedge clk);
    chk("t5_dm_rvalid", 32'(dm_rvalid), 1);
    chk("t5_dm_rdata", 32'(dm_rdata), 32'h5A5A);
    step(); if_req = 1'b0;

    // Reset between a read grant and its return
    dm_req = 1'b1; dm_addr = 16'h0201;
    @(negedge clk);
    chk("t6_dm_gnt", 32'(dm_gnt), 1);
    #1 rst = 1'b0;
    dm_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_dm_rvalid_dropped", 32'(dm_rvalid), 0);
    chk("t6_halted_cleared", 32'(halted), 0);
    step(); rst = 1'b1;
    @(negedge clk);
    chk("t6_post_dm_rvalid", 32'(dm_rvalid), 0);
    chk("t6_post_if_rvalid", 32'(if_rvalid), 0);
    step();
    if_req = 1'b1; if_addr = 16'h0010;
    @(negedge clk);
    chk("t6_fetch_after_reset", 32'(if_gnt), 1);
    step(); if_req = 1'b0;
    @(negedge clk);
    chk("t6_fetch_rdata", 32'(if_rdata), 32'h1234);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous unified memory between the CPU's instruction-fetch port and its data load/store port. At most one access is granted per cycle. Data accesses have priority, with a bounded-starvation guard that protects fetch. The block also detects the halt instruction on the fetch return path and then stops all further fetch grants, which gives the run controller a clean stop point before the memory dump.

Parameters:
ADDR_W, 16, address width of both requesters and the memory.
DATA_W, 16, data/instruction width.
MAX_WAIT, 4, consecutive denied fetch cycles after which fetch wins arbitration once (range 1..15).
HALT_OPCODE, 16'hF000, fetched word that sets halted.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset; asynchronous, active-low (asserted at 0).
if_req  in  1  fetch request; held until if_gnt.
if_addr  in  ADDR_W  fetch address.
if_gnt  out  1  fetch accepted this cycle (combinational).
if_rvalid  out  1  fetch data valid (one cycle after if_gnt).
if_rdata  out  DATA_W  fetched word.
dm_req  in  1  data request; held until dm_gnt.
dm_we  in  1  1 = write, 0 = read.
dm_addr  in  ADDR_W  data address.
dm_wdata  in  DATA_W  write data.
dm_gnt  out  1  data access accepted this cycle (combinational).
dm_rvalid  out  1  read data valid (one cycle after a read grant).
dm_rdata  out  DATA_W  read data.
mem_en  out  1  memory access strobe.
mem_we  out  1  memory write enable.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_rdata  in  DATA_W  memory read data; 1-cycle latency after mem_en with mem_we = 0.
halted  out  1  sticky; halt opcode has been fetched.

Behaviour:
- Reset (rst = 0, asynchronous):
  - starve_cnt = 0, owner = NONE, halted = 0.
  - if_rvalid = 0, dm_rvalid = 0.
  - Grants and mem_en are forced to 0 while rst = 0.
- Fetch eligibility: fetch_ok = if_req & ~halted.
- Arbitration (combinational, single cycle):
  - If starve_cnt == MAX_WAIT and fetch_ok: fetch wins.
  - Otherwise, if dm_req: data wins.
  - Otherwise, if fetch_ok: fetch wins.
  - Otherwise: no grant.
  - At most one of if_gnt and dm_gnt is high in any cycle.
- Memory drive:
  - mem_en = if_gnt | dm_gnt.
  - mem_we = dm_gnt & dm_we.
  - mem_addr and mem_wdata are muxed from the winner.
  - When idle, mem_addr and mem_wdata = 0.
- Return path:
  - owner register, values NONE / IF / DM, is updated every cycle.
  - owner = IF on a fetch grant; DM on a data read grant; NONE on a data write grant or no grant.
  - Next cycle: if_rvalid = (owner == IF) and dm_rvalid = (owner == DM).
  - mem_rdata is routed to both rdata outputs; an rdata output is valid only while its rvalid is high.
  - Read latency is exactly 1. Back-to-back grants are allowed, giving full throughput.
  - Writes never produce an rvalid.
- Starvation counter:
  - Increments when fetch_ok and not if_gnt.
  - Clears when if_gnt or ~fetch_ok.
  - Saturates at MAX_WAIT.
- Halt:
  - When if_rvalid and if_rdata == HALT_OPCODE, halted is set on the next edge and stays set until reset.
  - A fetch granted in the same cycle that halted is still being detected completes normally, including its rvalid.
  - Once halted = 1, no further fetch grants are issued.
- Data accesses are unaffected by halted and keep being served (stores drain).
- Simultaneous if_req and dm_req with starve_cnt < MAX_WAIT: data wins.
- Reset mid-access: any pending rvalid is dropped and never delivered.

Decomposition:
- Shared package (cpu_mem_pkg) holds:
  - the owner encoding constants OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_DM = 2'd2;
  - HALT_OPCODE;
  - the ADDR_W / DATA_W defaults.
- One natural sub-module: mem_arb_starve_ctr, the saturating starvation counter with a wait_max output.
- Arbitration mux, owner register and halt flag stay in the top module.

Test Plan:
- Reset, then a lone fetch to 0x0010 with mem_rdata = 0x1234 → if_gnt = 1 that cycle; next cycle if_rvalid = 1 with if_rdata = 0x1234; all outputs are 0 during reset.
- Data write to 0x0100 with wdata 0xBEEF, issued together with a fetch → dm_gnt = 1, mem_we = 1, mem_addr = 0x0100; if_gnt = 0; no dm_rvalid on the following cycle.
- dm_req held high for 10 cycles with if_req also held high, MAX_WAIT = 4 → if_gnt occurs on cycle 5 and again on cycle 10; all other cycles go to data; starve_cnt returns to 0 after each fetch grant.
- Fetch returns 0xF000 → halted = 1 on the next edge; a held if_req then never receives if_gnt; a subsequent data read of 0x0200 is still granted and returns dm_rvalid one cycle later.
- Back-to-back fetch reads of 0x0000, 0x0001, 0x0002 → three consecutive if_gnt; if_rvalid is high for three consecutive cycles, each one cycle late, with matching data.
- Data read granted, then rst = 0 asserted before the next edge → dm_rvalid stays 0; after release, owner = NONE and halted = 0.
